mem_arbiter: RTL and testbench
==============================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter ADDR_W, default 32, memory address width.
REQ-002 SHALL have parameter DATA_W, default 32, memory data width.
REQ-003 SHALL have parameter STARVE_MAX, default 4, max consecutive load/store grants while fetch waits (1..7).
REQ-004 SHALL have port clk  input  1  sole clock, all state on rising edge.
REQ-005 SHALL have port rst  input  1  asynchronous, active-low reset.
REQ-006 SHALL have ports if_req input 1, if_addr input ADDR_W: fetch request and address, held stable until if_gnt.
REQ-007 SHALL have ports if_gnt output 1, if_rvalid output 1, if_rdata output DATA_W: fetch accept pulse, response pulse, response data.
REQ-008 SHALL have ports ls_req input 1, ls_we input 1, ls_addr input ADDR_W, ls_wdata input DATA_W, ls_be input DATA_W/8: load/store request, held stable until ls_gnt.
REQ-009 SHALL have ports ls_gnt output 1, ls_rvalid output 1, ls_rdata output DATA_W: load/store accept pulse, response/write-ack pulse, read data.
REQ-010 SHALL have ports mem_req, mem_we output 1; mem_addr output ADDR_W; mem_wdata output DATA_W; mem_be output DATA_W/8: single memory port request.
REQ-011 SHALL have ports mem_gnt input 1, mem_rvalid input 1, mem_rdata input DATA_W: memory accept, response/write-ack, read data.
REQ-012 SHALL have port err_unexp output 1: one-cycle pulse on a response with no outstanding transaction.

Function
REQ-013 SHALL implement FSM states IDLE, ISSUE, WAIT; at most one memory transaction outstanding.
REQ-014 IDLE: if any request, SHALL latch winner (owner), its we/addr/wdata/be (fetch: we=0, be=all ones), and go ISSUE next cycle; else stay IDLE.
REQ-015 Arbitration: ls_req only -> LS; if_req only -> IF; both -> LS unless starve count == STARVE_MAX, then IF.
REQ-016 Starve count (3 bits) SHALL increment on each LS latch while if_req=1, saturate at STARVE_MAX, clear on IF latch.
REQ-017 ISSUE: mem_req=1 with latched fields, held unchanged until mem_gnt=1; on mem_gnt go WAIT.
REQ-018 SHALL pulse owner's gnt (if_gnt or ls_gnt) combinationally in the cycle mem_gnt=1 in ISSUE; other gnt stays 0.
REQ-019 mem_req SHALL be 0 in IDLE and WAIT; mem_we/addr/wdata/be hold latched values.
REQ-020 WAIT: on mem_rvalid=1, pulse owner's rvalid same cycle, drive owner's rdata=mem_rdata, return to IDLE next cycle.
REQ-021 Writes SHALL complete identically: mem_rvalid is the write ack, routed to ls_rvalid.
REQ-022 if_rdata and ls_rdata SHALL equal mem_rdata continuously; only the rvalid pulses are gated by owner.
REQ-023 Minimum transaction: request seen in IDLE cycle N, mem_req cycle N+1, response earliest N+2, next arbitration N+3 (one idle bubble).
REQ-024 mem_rvalid in IDLE or ISSUE SHALL be dropped (no rvalid to either requester) and pulse err_unexp.
REQ-025 mem_rvalid and mem_gnt in the same ISSUE cycle SHALL treat rvalid as unexpected (REQ-024) and gnt normally.
REQ-026 Requests deasserting while not granted are a protocol violation; behaviour unspecified, no recovery required.

Reset
REQ-027 On rst=0, SHALL immediately force state IDLE, owner=LS, starve count 0, latched fields 0.
REQ-028 During reset all outputs SHALL be 0 (mem_req, gnts, rvalids, err_unexp, mem_we/addr/wdata/be); rdata outputs follow mem_rdata.
REQ-029 Reset mid-transaction SHALL abandon it; a late mem_rvalid after reset release is handled by REQ-024.

Structure
REQ-030 Shared package cpu_pkg SHALL hold owner enum (OWN_IF, OWN_LS) and arbiter state enum (ARB_IDLE, ARB_ISSUE, ARB_WAIT).
REQ-031 Priority selection (REQ-015) SHALL be a combinational sub-module mem_arb_pick (inputs if_req, ls_req, starve_hit; output owner, valid).

Verification
REQ-032 Fetch alone: if_req=1, if_addr=0x10, mem_gnt same cycle as mem_req, mem_rvalid next, mem_rdata=0x00500093 -> one if_gnt, one if_rvalid with if_rdata=0x00500093, mem_we=0.
REQ-033 Store: ls_we=1, ls_addr=0x100, ls_wdata=0x8, ls_be=0xF -> mem_we=1, mem_addr=0x100, mem_wdata=0x8, mem_be=0xF, ls_rvalid on ack, if_rvalid stays 0.
REQ-034 Starvation: if_req and ls_req held high, STARVE_MAX=4 -> grant order LS,LS,LS,LS,IF, repeating.
REQ-035 Stall: mem_gnt held 0 for 5 cycles in ISSUE -> mem_req and fields stable for all 5 cycles, single gnt when mem_gnt rises.
REQ-036 Reset mid-WAIT then mem_rvalid one cycle after release -> no if_rvalid/ls_rvalid, err_unexp=1 for one cycle, next request served normally.
REQ-037 Bench SHALL check at every cycle: mem_req never high outside ISSUE, gnt and rvalid pulses one-hot and one cycle wide.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared types for the CPU memory path: requester identity and arbiter state.
package cpu_pkg;

    typedef enum logic {
        OWN_IF = 1'b0,
        OWN_LS = 1'b1
    } owner_e;

    typedef enum logic [1:0] {
        ARB_IDLE  = 2'd0,
        ARB_ISSUE = 2'd1,
        ARB_WAIT  = 2'd2
    } arb_state_e;

    localparam int STARVE_W = 3;

endpackage

// File: rtl/mem_arb_pick.sv
// Priority pick between fetch and load/store; load/store wins unless fetch is starved.
module mem_arb_pick
    import cpu_pkg::*;
(
    input  logic   if_req,
    input  logic   ls_req,
    input  logic   starve_hit,
    output owner_e owner,
    output logic   valid
);

    always_comb begin
        valid = if_req | ls_req;
        owner = OWN_LS;
        if (if_req && (!ls_req || starve_hit)) begin
            owner = OWN_IF;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Single-outstanding arbiter sharing one memory port between instruction fetch and load/store.
module mem_arbiter
    import cpu_pkg::*;
#(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int STARVE_MAX = 4
) (
    input  logic                clk,
    input  logic                rst,

    input  logic                if_req,
    input  logic [ADDR_W-1:0]   if_addr,
    output logic                if_gnt,
    output logic                if_rvalid,
    output logic [DATA_W-1:0]   if_rdata,

    input  logic                ls_req,
    input  logic                ls_we,
    input  logic [ADDR_W-1:0]   ls_addr,
    input  logic [DATA_W-1:0]   ls_wdata,
    input  logic [DATA_W/8-1:0] ls_be,
    output logic                ls_gnt,
    output logic                ls_rvalid,
    output logic [DATA_W-1:0]   ls_rdata,

    output logic                mem_req,
    output logic                mem_we,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic [DATA_W-1:0]   mem_wdata,
    output logic [DATA_W/8-1:0] mem_be,
    input  logic                mem_gnt,
    input  logic                mem_rvalid,
    input  logic [DATA_W-1:0]   mem_rdata,

    output logic                err_unexp,
    output arb_state_e          dbg_state
);

    localparam int BE_W = DATA_W / 8;
    localparam logic [STARVE_W-1:0] STARVE_LIM = STARVE_W'(STARVE_MAX);

    // Handshake: a requester holds req and its fields until its gnt pulse;
    // gnt marks acceptance by memory, rvalid marks the single response (or write ack).

    arb_state_e          state_q, state_d;
    owner_e              owner_q, owner_d;
    logic [STARVE_W-1:0] starve_q, starve_d;
    logic                we_q, we_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic [BE_W-1:0]     be_q, be_d;

    owner_e pick_owner;
    logic   pick_valid;
    logic   starve_hit;
    logic   granted;
    logic   responded;

    assign starve_hit = (starve_q == STARVE_LIM);

    mem_arb_pick u_pick (
        .if_req     (if_req),
        .ls_req     (ls_req),
        .starve_hit (starve_hit),
        .owner      (pick_owner),
        .valid      (pick_valid)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= ARB_IDLE;
            owner_q  <= OWN_LS;
            starve_q <= '0;
            we_q     <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
            be_q     <= '0;
        end else begin
            state_q  <= state_d;
            owner_q  <= owner_d;
            starve_q <= starve_d;
            we_q     <= we_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            be_q     <= be_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        owner_d  = owner_q;
        starve_d = starve_q;
        we_d     = we_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        be_d     = be_q;
        unique case (state_q)
            ARB_IDLE: begin
                if (pick_valid) begin
                    owner_d = pick_owner;
                    state_d = ARB_ISSUE;
                    if (pick_owner == OWN_LS) begin
                        we_d    = ls_we;
                        addr_d  = ls_addr;
                        wdata_d = ls_wdata;
                        be_d    = ls_be;
                        // Only a waiting fetch counts as starved; saturate at the limit.
                        if (if_req && !starve_hit) begin
                            starve_d = starve_q + 3'd1;
                        end
                    end else begin
                        we_d     = 1'b0;
                        addr_d   = if_addr;
                        wdata_d  = '0;
                        be_d     = '1;
                        starve_d = '0;
                    end
                end
            end
            ARB_ISSUE: begin
                if (mem_gnt) begin
                    state_d = ARB_WAIT;
                end
            end
            ARB_WAIT: begin
                if (mem_rvalid) begin
                    state_d = ARB_IDLE;
                end
            end
            default: state_d = ARB_IDLE;
        endcase
    end

    assign granted   = (state_q == ARB_ISSUE) && mem_gnt;
    assign responded = (state_q == ARB_WAIT) && mem_rvalid;

    assign mem_req   = (state_q == ARB_ISSUE);
    assign mem_we    = we_q;
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;
    assign mem_be    = be_q;

    assign if_gnt    = granted && (owner_q == OWN_IF);
    assign ls_gnt    = granted && (owner_q == OWN_LS);
    assign if_rvalid = responded && (owner_q == OWN_IF);
    assign ls_rvalid = responded && (owner_q == OWN_LS);
    assign if_rdata  = mem_rdata;
    assign ls_rdata  = mem_rdata;

    // A response outside WAIT has no owner; it is dropped and flagged (masked in reset).
    assign err_unexp = rst && mem_rvalid && (state_q != ARB_WAIT);
    assign dbg_state = state_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: directed requesters, a memory responder and a monitor.
module tb_mem_arbiter;
  import cpu_pkg::*;

  typedef struct {
    bit          is_ls;
    bit          we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
    int          stalls;
  } gnt_t;

  typedef struct {
    bit          is_ls;
    bit          chk;
    logic [31:0] data;
  } rsp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        if_req = 1'b0;
  logic [31:0] if_addr = '0;
  logic        if_gnt, if_rvalid;
  logic [31:0] if_rdata;
  logic        ls_req = 1'b0;
  logic        ls_we = 1'b0;
  logic [31:0] ls_addr = '0;
  logic [31:0] ls_wdata = '0;
  logic [3:0]  ls_be = '0;
  logic        ls_gnt, ls_rvalid;
  logic [31:0] ls_rdata;
  logic        mem_req, mem_we;
  logic [31:0] mem_addr, mem_wdata;
  logic [3:0]  mem_be;
  logic        mem_gnt = 1'b0;
  logic        mem_rvalid = 1'b0;
  logic [31:0] mem_rdata = '0;
  logic        err_unexp;
  arb_state_e  dbg_state;

  int n_tests = 0;
  int n_fail  = 0;

  gnt_t exp_gnt_q[$];
  rsp_t exp_rsp_q[$];
  int   exp_err = 0;

  logic [31:0] mem_model [logic [31:0]];
  int          stall_cycles = 0;
  bit          hold_resp = 0;
  bit          inject_rv = 0;
  bit          pend = 0;
  logic [31:0] pend_data = '0;
  int          stall_cnt = 0;

  mem_arbiter dut (
    .clk        (clk),
    .rst        (rst),
    .if_req     (if_req),
    .if_addr    (if_addr),
    .if_gnt     (if_gnt),
    .if_rvalid  (if_rvalid),
    .if_rdata   (if_rdata),
    .ls_req     (ls_req),
    .ls_we      (ls_we),
    .ls_addr    (ls_addr),
    .ls_wdata   (ls_wdata),
    .ls_be      (ls_be),
    .ls_gnt     (ls_gnt),
    .ls_rvalid  (ls_rvalid),
    .ls_rdata   (ls_rdata),
    .mem_req    (mem_req),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_be     (mem_be),
    .mem_gnt    (mem_gnt),
    .mem_rvalid (mem_rvalid),
    .mem_rdata  (mem_rdata),
    .err_unexp  (err_unexp),
    .dbg_state  (dbg_state)
  );

  // ---------------- clock / watchdog ----------------
  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail + 1);
    $fatal(1, "watchdog");
  end

  // ---------------- helpers ----------------
  function automatic void check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endfunction

  function automatic void fail(input string name);
    n_tests++;
    n_fail++;
    $display("FAIL %s", name);
  endfunction

  function automatic void push_gnt(input bit is_ls, input bit we, input logic [31:0] addr,
                                   input logic [31:0] wdata, input logic [3:0] be, input int stalls);
    gnt_t g;
    g.is_ls = is_ls; g.we = we; g.addr = addr; g.wdata = wdata; g.be = be; g.stalls = stalls;
    exp_gnt_q.push_back(g);
  endfunction

  function automatic void push_rsp(input bit is_ls, input bit chk, input logic [31:0] data);
    rsp_t r;
    r.is_ls = is_ls; r.chk = chk; r.data = data;
    exp_rsp_q.push_back(r);
  endfunction

  // ---------------- driver tasks ----------------
  task automatic req_if(input logic [31:0] addr);
    int n = 0;
    if_addr = addr;
    if_req  = 1'b1;
    forever begin
      @(negedge clk);
      if (if_gnt) break;
      n++;
      if (n >= 200) begin fail("if_gnt_timeout"); break; end
    end
    @(posedge clk); #2;
    if_req = 1'b0;
  endtask

  task automatic req_ls(input bit we, input logic [31:0] addr, input logic [31:0] wdata, input logic [3:0] be);
    int n = 0;
    ls_we    = we;
    ls_addr  = addr;
    ls_wdata = wdata;
    ls_be    = be;
    ls_req   = 1'b1;
    forever begin
      @(negedge clk);
      if (ls_gnt) break;
      n++;
      if (n >= 200) begin fail("ls_gnt_timeout"); break; end
    end
    @(posedge clk); #2;
    ls_req = 1'b0;
  endtask

  task automatic wait_drain();
    int n = 0;
    while ((exp_rsp_q.size() != 0 || exp_gnt_q.size() != 0 || dbg_state != ARB_IDLE) && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (n >= 300) fail("drain_timeout");
    @(posedge clk); #2;
  endtask

  // ---------------- memory responder ----------------
  initial begin : responder
    logic [31:0] word;
    forever begin
      @(posedge clk); #1;
      mem_gnt    = 1'b0;
      mem_rvalid = 1'b0;
      if (pend || inject_rv) begin
        mem_rvalid = 1'b1;
        mem_rdata  = pend ? pend_data : 32'hBAD0_0000;
        pend       = 0;
        inject_rv  = 0;
      end
      if (mem_req) begin
        if (stall_cnt < stall_cycles) begin
          stall_cnt++;
        end else begin
          mem_gnt   = 1'b1;
          stall_cnt = 0;
          word = mem_model.exists(mem_addr) ? mem_model[mem_addr] : 32'h0;
          if (mem_we) begin
            for (int b = 0; b < 4; b++)
              if (mem_be[b]) word[8*b +: 8] = mem_wdata[8*b +: 8];
            mem_model[mem_addr] = word;
            pend_data = 32'h0;
          end else begin
            pend_data = word;
          end
          if (!hold_resp) pend = 1;
        end
      end
    end
  end

  // ---------------- monitor / scoreboard ----------------
  bit          prev_gnt = 0, prev_rv = 0, prev_stall = 0;
  logic        p_we;
  logic [31:0] p_addr, p_wdata;
  logic [3:0]  p_be;
  int          stall_seen = 0;

  initial begin : monitor
    gnt_t g;
    rsp_t r;
    forever begin
      @(negedge clk);
      if (!rst) begin
        prev_gnt = 0; prev_rv = 0; prev_stall = 0; stall_seen = 0;
        continue;
      end
      check("mem_req_vs_state", mem_req, dbg_state == ARB_ISSUE);
      check("gnt_onehot", if_gnt & ls_gnt, 0);
      check("rvalid_onehot", if_rvalid & ls_rvalid, 0);
      check("gnt_width", prev_gnt & (if_gnt | ls_gnt), 0);
      check("rvalid_width", prev_rv & (if_rvalid | ls_rvalid), 0);
      check("rdata_follow", {if_rdata, ls_rdata}, {mem_rdata, mem_rdata});
      if (prev_stall && mem_req)
        check("stall_fields", {mem_we, mem_addr, mem_wdata, mem_be}, {p_we, p_addr, p_wdata, p_be});

      if (if_gnt || ls_gnt) begin
        if (exp_gnt_q.size() == 0) begin
          fail("gnt_unexpected");
        end else begin
          g = exp_gnt_q.pop_front();
          check("gnt_owner_ls", ls_gnt, g.is_ls);
          check("gnt_mem_we", mem_we, g.we);
          check("gnt_mem_addr", mem_addr, g.addr);
          check("gnt_mem_be", mem_be, g.be);
          if (g.is_ls && g.we) check("gnt_mem_wdata", mem_wdata, g.wdata);
          check("gnt_stall_cycles", stall_seen, g.stalls);
        end
        stall_seen = 0;
      end else if (mem_req) begin
        stall_seen++;
      end

      if (if_rvalid || ls_rvalid) begin
        if (exp_rsp_q.size() == 0) begin
          fail("rvalid_unexpected");
        end else begin
          r = exp_rsp_q.pop_front();
          check("rsp_owner_ls", ls_rvalid, r.is_ls);
          if (r.chk) check("rsp_data", r.is_ls ? ls_rdata : if_rdata, r.data);
        end
      end

      if (err_unexp) begin
        if (exp_err > 0) exp_err--;
        else fail("err_unexp_unexpected");
      end

      prev_stall = mem_req && !mem_gnt;
      p_we = mem_we; p_addr = mem_addr; p_wdata = mem_wdata; p_be = mem_be;
      prev_gnt = if_gnt | ls_gnt;
      prev_rv  = if_rvalid | ls_rvalid;
    end
  end

  // ---------------- directed stimulus ----------------
  bit order [12] = '{1, 1, 1, 1, 0, 1, 1, 1, 1, 0, 1, 1};

  initial begin : stimulus
    int li, fi;
    logic [31:0] fetch_addr [2];
    logic [31:0] fetch_data [2];
    fetch_addr[0] = 32'h40; fetch_data[0] = 32'h1111_0040;
    fetch_addr[1] = 32'h44; fetch_data[1] = 32'h2222_0044;

    mem_model[32'h10] = 32'h0050_0093;
    mem_model[32'h40] = 32'h1111_0040;
    mem_model[32'h44] = 32'h2222_0044;
    mem_model[32'h80] = 32'h3333_0080;
    for (int i = 0; i < 10; i++) mem_model[32'(32'h200 + 4 * i)] = 32'(32'hA000_0000 + i);

    // Reset state, including a stray response that must not flag during reset.
    repeat (2) @(negedge clk);
    check("rst_outputs", {mem_req, if_gnt, ls_gnt, if_rvalid, ls_rvalid, err_unexp,
                          mem_we, mem_addr, mem_wdata, mem_be}, 0);
    check("rst_state", dbg_state, ARB_IDLE);
    inject_rv = 1;
    @(negedge clk);
    check("rst_stray_rvalid", {err_unexp, if_rvalid, ls_rvalid}, 0);
    check("rst_rdata_follow", if_rdata, 32'hBAD0_0000);
    @(posedge clk); #2;
    rst = 1'b1;
    repeat (2) @(posedge clk); #2;

    // Fetch alone.
    push_gnt(0, 0, 32'h10, 32'h0, 4'hF, 0);
    push_rsp(0, 1, 32'h0050_0093);
    req_if(32'h10);
    wait_drain();

    // Full-word store, then a halfword-enable store, then a readback.
    push_gnt(1, 1, 32'h100, 32'h8, 4'hF, 0);
    push_rsp(1, 0, 32'h0);
    req_ls(1, 32'h100, 32'h8, 4'hF);
    wait_drain();
    push_gnt(1, 1, 32'h100, 32'hDEAD_BEEF, 4'h3, 0);
    push_rsp(1, 0, 32'h0);
    req_ls(1, 32'h100, 32'hDEAD_BEEF, 4'h3);
    wait_drain();
    push_gnt(1, 0, 32'h100, 32'h0, 4'hF, 0);
    push_rsp(1, 1, 32'h0000_BEEF);
    req_ls(0, 32'h100, 32'h0, 4'hF);
    wait_drain();

    // Memory stalls the grant for five cycles.
    stall_cycles = 5;
    push_gnt(0, 0, 32'h44, 32'h0, 4'hF, 5);
    push_rsp(0, 1, 32'h2222_0044);
    req_if(32'h44);
    wait_drain();
    stall_cycles = 0;

    // Both requesters busy: LS x4 then IF, repeating.
    li = 0; fi = 0;
    for (int k = 0; k < 12; k++) begin
      if (order[k]) begin
        push_gnt(1, 0, 32'(32'h200 + 4 * li), 32'h0, 4'hF, 0);
        push_rsp(1, 1, 32'(32'hA000_0000 + li));
        li++;
      end else begin
        push_gnt(0, 0, fetch_addr[fi], 32'h0, 4'hF, 0);
        push_rsp(0, 1, fetch_data[fi]);
        fi++;
      end
    end
    fork
      begin
        for (int i = 0; i < 10; i++) req_ls(0, 32'(32'h200 + 4 * i), 32'h0, 4'hF);
      end
      begin
        for (int i = 0; i < 2; i++) req_if(fetch_addr[i]);
      end
    join
    wait_drain();

    // Reset while waiting for a response; the late response is unexpected.
    hold_resp = 1;
    push_gnt(0, 0, 32'h80, 32'h0, 4'hF, 0);
    req_if(32'h80);
    @(negedge clk);
    check("midwait_state", dbg_state, ARB_WAIT);
    rst = 1'b0;
    @(negedge clk);
    check("midwait_rst_outputs", {mem_req, if_gnt, ls_gnt, if_rvalid, ls_rvalid, err_unexp,
                                  mem_we, mem_addr, mem_wdata, mem_be}, 0);
    check("midwait_rst_state", dbg_state, ARB_IDLE);
    @(posedge clk); #2;
    rst = 1'b1;
    hold_resp = 0;
    exp_err = 1;
    @(negedge clk);
    inject_rv = 1;
    repeat (3) @(negedge clk);
    check("late_rvalid_err", exp_err, 0);

    // Service resumes normally.
    push_gnt(0, 0, 32'h10, 32'h0, 4'hF, 0);
    push_rsp(0, 1, 32'h0050_0093);
    req_if(32'h10);
    wait_drain();

    check("gnt_queue_empty", exp_gnt_q.size(), 0);
    check("rsp_queue_empty", exp_rsp_q.size(), 0);
    check("err_all_seen", exp_err, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
